// File: rtl/mul_share_sched.sv
// Round-robin front end that time-shares one fixed-latency multiplier among NUM_REQ requesters.
// Requester IDs ride a tag pipeline alongside the multiplier so each product is routed back.
module mul_share_sched #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 8,
    parameter int LATENCY = 3
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*WIDTH-1:0]       req_a,
    input  logic [NUM_REQ*WIDTH-1:0]       req_b,
    output logic [WIDTH-1:0]               mul_I0,
    output logic [WIDTH-1:0]               mul_I1,
    input  logic [WIDTH-1:0]               mul_O,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [WIDTH-1:0]               rsp_data,
    output logic [$clog2(LATENCY+2)-1:0]   inflight
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int CW  = $clog2(LATENCY+2);
    localparam logic [IDW:0]   NUM_REQ_W = (IDW+1)'(NUM_REQ);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ-1);

    logic [IDW-1:0] rr;
    logic [IDW:0]   scan;
    logic           grant_found;
    logic [IDW-1:0] grant_id;
    logic           transfer;

    logic [WIDTH-1:0] a_arr [NUM_REQ];
    logic [WIDTH-1:0] b_arr [NUM_REQ];

    logic           tag_valid [LATENCY];
    logic [IDW-1:0] tag_id    [LATENCY];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
        assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end

    // Handshake: requester i transfers in a cycle where req_valid[i] && req_ready[i];
    // req_ready is a function of req_valid and rr only, and is forced low during reset.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan        = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan = {1'b0, rr} + (IDW+1)'(k);
            if (scan >= NUM_REQ_W) scan = scan - NUM_REQ_W;
            if (!grant_found && req_valid[scan[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = scan[IDW-1:0];
            end
        end
    end

    assign transfer = grant_found && !reset;

    // Idle cycles feed zeros; those products carry no valid tag and are dropped.
    always_comb begin
        req_ready = '0;
        mul_I0    = '0;
        mul_I1    = '0;
        if (transfer) begin
            req_ready[grant_id] = 1'b1;
            mul_I0              = a_arr[grant_id];
            mul_I1              = b_arr[grant_id];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rr        <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            inflight  <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                tag_valid[k] <= 1'b0;
                tag_id[k]    <= '0;
            end
        end else begin
            tag_valid[0] <= transfer;
            tag_id[0]    <= grant_id;
            for (int k = 1; k < LATENCY; k++) begin
                tag_valid[k] <= tag_valid[k-1];
                tag_id[k]    <= tag_id[k-1];
            end

            if (tag_valid[LATENCY-1]) begin
                rsp_valid <= NUM_REQ'(1) << tag_id[LATENCY-1];
                rsp_data  <= mul_O;
            end else begin
                rsp_valid <= '0;
            end

            if (transfer) rr <= (grant_id == LAST_ID) ? '0 : grant_id + IDW'(1);

            // Count issued operations until their response strobe has been shown.
            case ({transfer, |rsp_valid})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

endmodule

// File: doc/mul_share_sched.md
# mul_share_sched

Round-robin scheduler that shares one fixed-latency 8-bit multiplier (`BlackBoxMulUInt8`, 3-stage, no reset, no handshake) among `NUM_REQ` requesters. Each requester issues operand pairs with valid/ready. The scheduler issues at most one operation per cycle into the multiplier and tracks requester IDs in a tag pipeline matched to the multiplier latency. It returns each product, registered, to the requester that issued it. It sits between operator lanes and a single multiplier instance in area-constrained pipelines.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: operand and product width; must equal the multiplier width.
- `LATENCY`, default 3: multiplier cycles from operand presentation to `O` valid.
- `clock` input 1: single clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high.
- `req_valid` input NUM_REQ: per-requester operation request.
- `req_ready` output NUM_REQ: per-requester accept; one-hot or zero.
- `req_a` input NUM_REQ*WIDTH: operand A; requester i occupies bits [i*WIDTH +: WIDTH].
- `req_b` input NUM_REQ*WIDTH: operand B, same packing as `req_a`.
- `mul_I0` output WIDTH: to multiplier `I0`.
- `mul_I1` output WIDTH: to multiplier `I1`.
- `mul_O` input WIDTH: from multiplier `O`.
- `rsp_valid` output NUM_REQ: one-hot response strobe, held one cycle.
- `rsp_data` output WIDTH: product, valid for the requester flagged in `rsp_valid`.
- `inflight` output clog2(LATENCY+2): number of issued operations whose response has not yet been presented.

## Operation
- **Arbitration:** combinational round-robin over `req_valid`.
  - Search starts at pointer `rr`, ascending, and wraps from NUM_REQ-1 to 0.
  - The first requester found with `req_valid` set is granted; `req_ready` is one-hot on that requester.
- **Handshake:** a transfer occurs when `req_valid[i] && req_ready[i]`.
  - `req_ready[i]` depends only on `req_valid` and `rr`. It never depends on the requester's own later state.
  - Requesters must hold `req_a`/`req_b` stable while valid is high and not yet accepted.
- **Pointer:** on a transfer to requester g, `rr <= (g+1) mod NUM_REQ`. With no transfer, `rr` holds.
- **Operands:**
  - `mul_I0`/`mul_I1` = the granted requester's `req_a`/`req_b`.
  - With no grant they are 0. Product 0 is discarded because its tag is invalid.
- **Tag pipeline:** LATENCY stages of {valid, id}.
  - Stage 0 captures {transfer, g} each cycle.
  - Stage k captures stage k-1.
- **Response register:** in the cycle when the last tag stage is valid, `mul_O` holds the product for that tag.
  - `rsp_valid <= onehot(id)` if the last stage is valid, else 0.
  - `rsp_data <= mul_O` if the last stage is valid, else hold the previous value.
- **No response backpressure:** requesters must accept `rsp_valid` unconditionally.
- **Inflight counter:** `inflight` increments on a transfer and decrements when `rsp_valid` is asserted. Both in one cycle leave it unchanged. Maximum value is LATENCY+1.
- **Reset values:** `rr`=0, all tag valids=0, `rsp_valid`=0, `rsp_data`=0, `inflight`=0.
  - `req_ready` is 0 during reset.
  - `mul_I0`/`mul_I1` are 0 during reset.
- **Reset mid-operation:** all in-flight operations are dropped with no `rsp_valid`. Multiplier contents are ignored because they are untagged. Arbitration resumes from requester 0 in the first cycle after reset deasserts.

## Timing
- **Throughput:** one operation per cycle total. Each requester gets at least one grant per NUM_REQ cycles while it holds `req_valid`.
- **Latency:** a transfer in cycle t gives `rsp_valid` and `rsp_data` in cycle t+LATENCY+1. This is 4 cycles with the defaults.
- **Ordering:** responses appear in issue order, at most one per cycle. Back-to-back issues give back-to-back responses.
- **Single requester:** a requester that holds `req_valid` alone is granted every cycle.
- **Combinational paths:** `req_valid` to `req_ready` and `req_valid` to `mul_I0`/`mul_I1` are combinational. All other outputs are registered.

## Test plan
- **Single request:** after reset, requester 1 presents a=7, b=6 for one cycle. Required: `req_ready`=0b0010 that cycle; 4 cycles later `rsp_valid`=0b0010 and `rsp_data`=42; `inflight` steps 0→1, then back to 0.
- **All requesters, held valid:** all 4 requesters hold valid with a=i+2, b=3. Required: grants 0,1,2,3,0,… one per cycle; responses 6,9,12,15 repeating in the same order, 4 cycles behind the grants; `inflight` saturates at 4.
- **Wrap:** `rr`=3 and only requesters 0 and 3 valid. Required: grant 3, then 0, then 3.
- **Truncation:** a=200, b=3. Required: `rsp_data`=88 (600 mod 256).
- **Reset mid-flight:** issue 3 operations, assert `reset` for 1 cycle 2 cycles after the first issue. Required: no `rsp_valid` afterward; `inflight`=0; next grant goes to the lowest valid index.
- **Idle gaps:** issue on cycles 0, 2 and 5. Required: `rsp_valid` on cycles 4, 6 and 9 only; `mul_I0`/`mul_I1`=0 on non-issue cycles.
